// File: rtl/goertzel_bin_scheduler.sv
// Frame sequencer that shares one Goertzel loop engine and post-process unit across
// the enabled frequency bins, one pass per ADC bank swap.
module goertzel_bin_scheduler #(
   parameter int NUM_BINS = 4,
   parameter int BIN_BITS = 2,
   parameter int D_W      = 16,
   parameter int TIMEOUT  = 1023,
   parameter int TO_W     = 10
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                bank_switch,
   input  logic [NUM_BINS-1:0] bin_mask,
   output logic [BIN_BITS-1:0] coef_addr,
   input  logic [D_W-1:0]      coef_sin,
   input  logic [D_W-1:0]      coef_cos,
   input  logic [D_W-1:0]      coef_inv_cos,
   output logic                eng_start,
   output logic [D_W-1:0]      eng_coeff,
   input  logic                eng_done,
   output logic                pp_en,
   output logic                pp_start,
   output logic [D_W-1:0]      pp_sin,
   output logic [D_W-1:0]      pp_inv_cos,
   input  logic                pp_done,
   input  logic [D_W-1:0]      pp_mag,
   output logic                res_valid,
   output logic [BIN_BITS-1:0] res_bin,
   output logic [D_W-1:0]      res_mag,
   output logic                frame_done,
   output logic                busy,
   output logic                overrun,
   output logic                timeout_err,
   input  logic                err_clr,
   output logic [3:0]          state_dbg
);

   // Handshake rule: eng_start/pp_start are single-cycle requests; eng_done/pp_done are
   // single-cycle completions honoured only in WAIT_LOOP/WAIT_PP, and res_valid qualifies
   // res_bin/res_mag for exactly one cycle with no backpressure.

   localparam int BW = BIN_BITS + 1;
   localparam logic [BW-1:0]   LAST_BIN = BW'(NUM_BINS);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      SCAN      = 4'd1,
      FETCH     = 4'd2,
      LOAD      = 4'd3,
      RUN       = 4'd4,
      WAIT_LOOP = 4'd5,
      POST      = 4'd6,
      WAIT_PP   = 4'd7,
      EMIT      = 4'd8,
      FIN       = 4'd9
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          sync_q;
   logic                swap_evt;
   logic [NUM_BINS-1:0] mask_q;
   logic [BW-1:0]       bin_q;
   logic [BIN_BITS-1:0] bin_idx;
   logic [BIN_BITS-1:0] addr_q;
   logic [D_W-1:0]      sin_q, cos_q, inv_q;
   logic [TO_W-1:0]     to_cnt_q;
   logic [BIN_BITS-1:0] res_bin_q;
   logic [D_W-1:0]      res_mag_q;
   logic                overrun_q, timeout_q;

   logic mask_load, bin_clr, bin_inc, addr_load, coef_load;
   logic cnt_clr, cnt_inc, res_load, to_set;

   // Any change of the synchronised level is a swap, whichever way it went.
   assign swap_evt = sync_q[1] ^ sync_q[0];
   assign bin_idx  = bin_q[BIN_BITS-1:0];

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], bank_switch};
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_load = 1'b0;
      bin_clr   = 1'b0;
      bin_inc   = 1'b0;
      addr_load = 1'b0;
      coef_load = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      res_load  = 1'b0;
      to_set    = 1'b0;
      case (state_q)
         IDLE: begin
            if (swap_evt) begin
               mask_load = 1'b1;
               bin_clr   = 1'b1;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (bin_q == LAST_BIN) begin
               state_d = FIN;
            end else if (!mask_q[bin_idx]) begin
               bin_inc = 1'b1;
            end else begin
               addr_load = 1'b1;
               state_d   = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            coef_load = 1'b1;
            state_d   = RUN;
         end
         RUN: begin
            cnt_clr = 1'b1;
            state_d = WAIT_LOOP;
         end
         WAIT_LOOP: begin
            if (eng_done) begin
               state_d = POST;
            end else if (to_cnt_q == TO_LIMIT) begin
               to_set  = 1'b1;
               state_d = FIN;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         POST: begin
            cnt_clr = 1'b1;
            state_d = WAIT_PP;
         end
         WAIT_PP: begin
            if (pp_done) begin
               res_load = 1'b1;
               state_d  = EMIT;
            end else if (to_cnt_q == TO_LIMIT) begin
               to_set  = 1'b1;
               state_d = FIN;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         EMIT: begin
            bin_inc = 1'b1;
            state_d = SCAN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         mask_q <= '0;
         bin_q  <= '0;
         addr_q <= '0;
      end else begin
         if (mask_load) mask_q <= bin_mask;
         if (bin_clr) begin
            bin_q <= '0;
         end else if (bin_inc) begin
            bin_q <= bin_q + BW'(1);
         end
         if (addr_load) addr_q <= bin_idx;
      end
   end

   // Coefficients stay in holding registers so the engines see stable operands for the whole bin.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sin_q <= '0;
         cos_q <= '0;
         inv_q <= '0;
      end else if (coef_load) begin
         sin_q <= coef_sin;
         cos_q <= coef_cos;
         inv_q <= coef_inv_cos;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (cnt_clr) begin
         to_cnt_q <= '0;
      end else if (cnt_inc) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         res_bin_q <= '0;
         res_mag_q <= '0;
      end else if (res_load) begin
         res_bin_q <= addr_q;
         res_mag_q <= pp_mag;
      end
   end

   // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (swap_evt && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end else if (err_clr) begin
            overrun_q <= 1'b0;
         end
         if (to_set) begin
            timeout_q <= 1'b1;
         end else if (err_clr) begin
            timeout_q <= 1'b0;
         end
      end
   end

   assign coef_addr   = addr_q;
   assign eng_start   = (state_q == RUN);
   assign eng_coeff   = {cos_q[D_W-2:0], 1'b0};
   assign pp_en       = (state_q == RUN) || (state_q == WAIT_LOOP) ||
                        (state_q == POST) || (state_q == WAIT_PP);
   assign pp_start    = (state_q == POST);
   assign pp_sin      = sin_q;
   assign pp_inv_cos  = inv_q;
   assign res_valid   = (state_q == EMIT);
   assign res_bin     = res_bin_q;
   assign res_mag     = res_mag_q;
   assign frame_done  = (state_q == FIN);
   assign busy        = (state_q != IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Directed bench: bench-side ROM, loop-engine and post-process models, with a scoreboard
// queue of expected results and frame ends checked by an independent monitor.
module tb_goertzel_bin_scheduler;

   localparam int W = 19;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        bank_switch;
   logic [3:0]  bin_mask;
   logic [1:0]  coef_addr;
   logic [15:0] coef_sin, coef_cos, coef_inv_cos;
   logic        eng_start;
   logic [15:0] eng_coeff;
   logic        eng_done;
   logic        pp_en, pp_start;
   logic [15:0] pp_sin, pp_inv_cos;
   logic        pp_done;
   logic [15:0] pp_mag;
   logic        res_valid;
   logic [1:0]  res_bin;
   logic [15:0] res_mag;
   logic        frame_done, busy, overrun, timeout_err;
   logic        err_clr;
   logic [3:0]  state_dbg;

   logic [15:0] rom_sin [4] = '{16'h3CC5, 16'h1111, 16'h4444, 16'h7777};
   logic [15:0] rom_cos [4] = '{16'h1413, 16'h2222, 16'h0555, 16'h3000};
   logic [15:0] rom_inv [4] = '{16'h7A63, 16'h3333, 16'h6666, 16'h1234};
   logic [15:0] exp_coeff [4] = '{16'h2826, 16'h4444, 16'h0AAA, 16'h6000};
   logic [15:0] mag_tab [4] = '{16'h1234, 16'h0BEE, 16'h0CAF, 16'h0D0D};

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int eng_lat = 20;
   int pp_lat = 4;
   bit eng_enable = 1'b1;
   logic [3:0] mask_cur = 4'h0;
   int eng_starts = 0;
   int res_seen = 0;
   int start_cyc = 0;
   int fd_cyc = 0;

   goertzel_bin_scheduler dut (
      .sys_clk(sys_clk), .rst(rst), .bank_switch(bank_switch), .bin_mask(bin_mask),
      .coef_addr(coef_addr), .coef_sin(coef_sin), .coef_cos(coef_cos),
      .coef_inv_cos(coef_inv_cos), .eng_start(eng_start), .eng_coeff(eng_coeff),
      .eng_done(eng_done), .pp_en(pp_en), .pp_start(pp_start), .pp_sin(pp_sin),
      .pp_inv_cos(pp_inv_cos), .pp_done(pp_done), .pp_mag(pp_mag),
      .res_valid(res_valid), .res_bin(res_bin), .res_mag(res_mag),
      .frame_done(frame_done), .busy(busy), .overrun(overrun),
      .timeout_err(timeout_err), .err_clr(err_clr), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   assign coef_sin     = rom_sin[coef_addr];
   assign coef_cos     = rom_cos[coef_addr];
   assign coef_inv_cos = rom_inv[coef_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic toggle_bank();
      @(negedge sys_clk);
      bank_switch = ~bank_switch;
   endtask

   task automatic issue_frame(input logic [3:0] mask, input bit with_results);
      @(negedge sys_clk);
      bin_mask = mask;
      mask_cur = mask;
      if (with_results) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) exp_q.push_back({1'b0, 2'(b), mag_tab[b]});
         end
      end
      exp_q.push_back({1'b1, 18'h0});
      toggle_bank();
   endtask

   task automatic wait_frame(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge sys_clk);
         if (frame_done) begin
            seen = 1'b1;
            fd_cyc = cyc;
         end
      end
      check(name, {31'h0, seen}, 32'h1);
   endtask

   task automatic pulse_err_clr();
      @(negedge sys_clk);
      err_clr = 1'b1;
      @(negedge sys_clk);
      err_clr = 1'b0;
   endtask

   // loop-engine model
   initial begin
      eng_done = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (eng_start && !rst) begin
            eng_starts++;
            start_cyc = cyc;
            check("eng_coeff", eng_coeff, exp_coeff[coef_addr]);
            check("bin_enabled", mask_cur[coef_addr], 1'b1);
            check("pp_en_at_start", pp_en, 1'b1);
            if (eng_enable) begin
               repeat (eng_lat - 1) @(negedge sys_clk);
               check("eng_coeff_held", eng_coeff, exp_coeff[coef_addr]);
               eng_done = 1'b1;
               @(negedge sys_clk);
               eng_done = 1'b0;
            end
         end
      end
   end

   // post-process model
   initial begin
      pp_done = 1'b0;
      pp_mag  = '0;
      forever begin
         @(negedge sys_clk);
         if (pp_start && !rst) begin
            check("pp_sin", pp_sin, rom_sin[coef_addr]);
            check("pp_inv_cos", pp_inv_cos, rom_inv[coef_addr]);
            repeat (pp_lat - 1) @(negedge sys_clk);
            pp_mag  = mag_tab[coef_addr];
            pp_done = 1'b1;
            @(negedge sys_clk);
            pp_done = 1'b0;
         end
      end
   end

   // scoreboard monitor
   initial begin
      logic [W-1:0] item;
      logic [W-1:0] act;
      forever begin
         @(negedge sys_clk);
         if (!rst && (res_valid || frame_done)) begin
            if (res_valid) res_seen++;
            act = frame_done ? {1'b1, 18'h0} : {1'b0, res_bin, res_mag};
            if (exp_q.size() == 0) begin
               check("unexpected_output", {13'h0, act}, 32'h0);
            end else begin
               item = exp_q.pop_front();
               check("scoreboard", {13'h0, act}, {13'h0, item});
            end
         end
      end
   end

   initial begin
      int d;
      int s0;
      rst = 1'b1;
      bank_switch = 1'b0;
      bin_mask = 4'h0;
      err_clr = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      rst = 1'b0;
      @(negedge sys_clk);
      check("rst_busy", busy, 1'b0);
      check("rst_flags", {res_valid, frame_done, overrun, timeout_err, eng_start, pp_en, pp_start}, 7'h0);
      check("rst_data", {coef_addr, eng_coeff, pp_sin}, 34'h0);
      check("rst_state", state_dbg, 4'h0);

      // single bin, long engine latency
      eng_lat = 515;
      pp_lat = 3;
      issue_frame(4'b0001, 1'b1);
      wait_frame(700, "frame_single");
      repeat (5) @(negedge sys_clk);

      // sparse mask: bins 1 then 3
      eng_lat = 20;
      s0 = eng_starts;
      issue_frame(4'b1010, 1'b1);
      wait_frame(300, "frame_sparse");
      check("sparse_starts", eng_starts - s0, 2);
      repeat (5) @(negedge sys_clk);

      // empty mask
      s0 = eng_starts;
      issue_frame(4'b0000, 1'b1);
      wait_frame(9, "frame_empty_fast");
      check("empty_no_start", eng_starts - s0, 0);
      repeat (5) @(negedge sys_clk);

      // overrun: second toggle mid-frame is dropped
      eng_lat = 120;
      s0 = eng_starts;
      issue_frame(4'b0011, 1'b1);
      repeat (100) @(negedge sys_clk);
      toggle_bank();
      repeat (4) @(negedge sys_clk);
      check("overrun_set", overrun, 1'b1);
      check("overrun_busy", busy, 1'b1);
      wait_frame(600, "frame_overrun");
      repeat (30) @(negedge sys_clk);
      check("no_second_frame", busy, 1'b0);
      check("overrun_starts", eng_starts - s0, 2);
      pulse_err_clr();
      check("overrun_clr", overrun, 1'b0);

      // timeout: engine never finishes
      eng_enable = 1'b0;
      issue_frame(4'b0001, 1'b0);
      wait_frame(1200, "frame_timeout");
      check("timeout_set", timeout_err, 1'b1);
      d = fd_cyc - start_cyc;
      checks++;
      if (d < 1024 || d > 1026) begin
         failures++;
         $display("FAIL timeout_latency actual=%0d required=1024..1026", d);
      end
      @(negedge sys_clk);
      check("timeout_idle", busy, 1'b0);
      pulse_err_clr();
      check("timeout_clr", timeout_err, 1'b0);
      eng_enable = 1'b1;
      eng_lat = 20;
      issue_frame(4'b0100, 1'b1);
      wait_frame(300, "frame_after_timeout");
      repeat (5) @(negedge sys_clk);

      // reset during WAIT_PP
      pp_lat = 60;
      eng_lat = 10;
      s0 = res_seen;
      @(negedge sys_clk);
      bin_mask = 4'b0001;
      mask_cur = 4'b0001;
      toggle_bank();
      d = 0;
      while (!pp_start && d < 100) begin
         @(negedge sys_clk);
         d++;
      end
      check("pp_start_seen", {31'h0, pp_start}, 32'h1);
      repeat (5) @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_flags", {res_valid, frame_done, eng_start, pp_en, pp_start}, 5'h0);
      check("midrst_data", {res_mag, eng_coeff, pp_sin, pp_inv_cos}, 64'h0);
      @(negedge sys_clk);
      rst = 1'b0;
      repeat (80) @(negedge sys_clk);
      check("midrst_no_result", res_seen - s0, 0);
      check("midrst_idle", busy, 1'b0);

      // final report
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/goertzel_bin_scheduler.md
Name: goertzel_bin_scheduler

Overview:
- Sequences one shared Goertzel loop engine and its post-process unit across up to NUM_BINS frequency bins for every ADC sample-bank swap.
- On each bank_switch toggle it walks the enabled bins in ascending order:
  - fetches each bin's SIN/COS/INV_COS from a coefficient ROM,
  - runs the accumulation loop, then the post-process,
  - emits one magnitude per bin.
- Sits between the ADC ping-pong sampler and the spectral result consumer. Replaces the hard-wired single-bin sequencer.

Parameters:
- NUM_BINS, 4, number of bin slots in the coefficient ROM.
- BIN_BITS, 2, width of bin index; NUM_BINS <= 2**BIN_BITS.
- D_W, 16, coefficient, magnitude and data width (Q2.14 signed).
- TIMEOUT, 1023, maximum cycles to wait for eng_done or pp_done before aborting.
- TO_W, 10, width of the timeout counter; must hold TIMEOUT.

Ports:
- sys_clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- bank_switch, in, 1, level toggled by the sampler on each bank swap; asynchronous to frame logic, so it is double-flopped.
- bin_mask, in, NUM_BINS, per-bin enable; sampled only at frame start.
- coef_addr, out, BIN_BITS, coefficient ROM address.
- coef_sin / coef_cos / coef_inv_cos, in, D_W each, ROM data; valid 1 cycle after coef_addr.
- eng_start, out, 1, one-cycle start pulse to the loop engine.
- eng_coeff, out, D_W, 2*cos in Q14, formed as {cos[D_W-2:0],1'b0}; held stable from eng_start until eng_done.
- eng_done, in, 1, loop engine completion pulse.
- pp_en, out, 1, post-process multiplier clock enable; high from eng_start through pp_done.
- pp_start, out, 1, one-cycle start pulse to the post-process unit.
- pp_sin / pp_inv_cos, out, D_W each, held stable from pp_start until pp_done.
- pp_done, in, 1, post-process done pulse.
- pp_mag, in, D_W, magnitude; valid in the cycle pp_done is high.
- res_valid, out, 1, one-cycle pulse per completed bin.
- res_bin, out, BIN_BITS, bin index of the result.
- res_mag, out, D_W, magnitude of the result.
- frame_done, out, 1, one-cycle pulse when all enabled bins are finished or the frame is aborted.
- busy, out, 1, high while not in IDLE.
- overrun, out, 1, sticky: a bank swap arrived while busy.
- timeout_err, out, 1, sticky: an engine did not respond within TIMEOUT.
- err_clr, in, 1, clears overrun and timeout_err.

Behaviour:
- Reset values:
  - all outputs 0, state IDLE.
  - sync flops = 00, so the first toggle after reset is detected as an edge.
- Swap detection: swap_evt = sync[1] ^ sync[0], after the 2-flop synchronizer. Any swap_evt (either polarity) is an event.
- States: IDLE, SCAN, FETCH, LOAD, RUN, WAIT_LOOP, POST, WAIT_PP, EMIT, FIN.
- IDLE: on swap_evt:
  - latch bin_mask into mask_q,
  - set bin = 0,
  - go to SCAN.
- SCAN:
  - if bin == NUM_BINS, go to FIN.
  - else if mask_q[bin] == 0, bin++ and stay in SCAN (one cycle per skipped bin).
  - else drive coef_addr = bin and go to FETCH.
- FETCH: wait one cycle for ROM data, then go to LOAD.
- LOAD: capture sin, cos and inv_cos into holding registers; go to RUN.
- RUN: pulse eng_start, raise pp_en, clear the timeout counter, go to WAIT_LOOP.
- WAIT_LOOP:
  - on eng_done, go to POST.
  - if the counter reaches TIMEOUT first, set timeout_err and go to FIN (frame aborted).
- POST: pulse pp_start, clear the counter, go to WAIT_PP.
- WAIT_PP:
  - on pp_done, capture pp_mag into res_mag and bin into res_bin, go to EMIT.
  - timeout handled exactly as in WAIT_LOOP.
- EMIT: pulse res_valid; drop pp_en; bin++; go to SCAN.
- FIN: pulse frame_done; go to IDLE.
- Latency per enabled bin: 5 overhead cycles plus engine time plus post-process time. Each skipped bin costs 1 cycle.
- Boundary conditions:
  - bin_mask == 0: frame_done 1 cycle after SCAN is exhausted; no res_valid.
  - swap_evt while busy: set overrun; the event is dropped, not queued; the current frame continues unaffected.
  - swap_evt in the same cycle FIN returns to IDLE: counts as busy, so the event is dropped and overrun is set.
  - eng_done or pp_done arriving outside its wait state: ignored.
  - err_clr together with a new error in the same cycle: the set wins.
  - rst mid-frame: immediate IDLE, all pulses low, no frame_done. Any swap_evt in progress is lost because the sync flops are cleared.
- No arithmetic other than the shift that forms eng_coeff. The MSB of cos is dropped; the ROM must keep |cos| < 1.0 in Q14.

Test Plan:
- Single bin: mask=0001, ROM[0]={sin 3CC5, cos 1413, inv 7A63}, toggle bank_switch; loop model returns eng_done 515 cycles later, post-process model returns 1234 → eng_coeff=2826, pp_sin=3CC5, pp_inv_cos=7A63, one res_valid with bin=0, mag=1234, then frame_done.
- Sparse mask: mask=1010 → results for bins 1 then 3 only, in that order; exactly 2 res_valid, then 1 frame_done; coef_addr never equals 0 or 2 during LOAD.
- Empty mask: mask=0000, toggle → frame_done within 8 cycles of the toggle; no eng_start, no res_valid.
- Overrun: toggle again 100 cycles into a frame → overrun=1; frame completes normally; no second frame starts; err_clr → overrun=0.
- Timeout: engine model never asserts eng_done → timeout_err=1 after 1023 cycles in WAIT_LOOP, frame_done pulses, busy=0; the next toggle runs a normal frame.
- Reset mid-frame: assert rst during WAIT_PP → the next cycle has busy=0 and all outputs 0; a late pp_done produces no res_valid.
